alu_op_sequencer: RTL and testbench

//  Upstream feeder and result collector for the combinational ALU.
//  - Accepts a 3-byte command stream (opcode, A, B) on a valid/ready byte interface.
//  - Drives the ALU operand, opcode and enable pins for one cycle, then latches the 16-bit result.
//  - Returns the result as a byte stream (LSB first) on a second valid/ready interface.

---
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Feeds a combinational ALU from a byte-wide command stream and returns the
// ALU result as a byte stream. A command is three bytes: opcode, A, B. The
// sequencer latches them, pulses alu_ena for one cycle, latches the result,
// and then streams it out LSB first.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_data/in_valid/in_ready  command byte stream
//   alu_a/alu_b/alu_opcode     registered ALU operands and opcode
//   alu_ena                    ALU enable, high for the single EXEC cycle
//   alu_result                 ALU result, 2*DATA_W wide
//   out_data/out_valid/out_ready  result byte stream
//   busy                       high whenever a command is in progress
//
// Build option: SEQ_STATUS_BYTE_EN appends a status byte
// {zeros, opcode[2:0], dz} after the two result bytes, where dz flags a
// div/mod with B == 0.
//
// state  | meaning
// IDLE   | waiting for opcode byte
// GET_A  | waiting for operand A
// GET_B  | waiting for operand B
// EXEC   | ALU enabled, result captured at end of cycle
// OUT_LO | presenting result low byte
// OUT_HI | presenting result high byte
// OUT_ST | presenting status byte (SEQ_STATUS_BYTE_EN only)

module alu_op_sequencer #(
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OPCODE_W-1:0]   alu_opcode,
    output logic                  alu_ena,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_EXEC   = 3'd3,
        S_OUT_LO = 3'd4,
        S_OUT_HI = 3'd5,
        S_OUT_ST = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [OPCODE_W-1:0]   r_op;
    logic [2*DATA_W-1:0]   r_result;
    logic                  w_in_ready;
    logic                  w_in_xfer;

`ifdef SEQ_STATUS_BYTE_EN
    logic                  r_dz;
    logic                  w_dz_nxt;
    logic [DATA_W-1:0]     w_status;

    assign w_dz_nxt = ((r_op == OPCODE_W'(3)) || (r_op == OPCODE_W'(4))) && (r_b == '0);
    assign w_status = {{(DATA_W-4){1'b0}}, r_op[2:0], r_dz};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        alu_ena     = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_GET_A;
            end
            S_GET_A: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_GET_B;
            end
            S_GET_B: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_ena     = 1'b1;
                w_state_nxt = S_OUT_LO;
            end
            S_OUT_LO: begin
                out_valid = 1'b1;
                out_data  = r_result[DATA_W-1:0];
                if (out_ready) w_state_nxt = S_OUT_HI;
            end
            S_OUT_HI: begin
                out_valid = 1'b1;
                out_data  = r_result[2*DATA_W-1:DATA_W];
                if (out_ready) begin
`ifdef SEQ_STATUS_BYTE_EN
                    w_state_nxt = S_OUT_ST;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef SEQ_STATUS_BYTE_EN
            S_OUT_ST: begin
                out_valid = 1'b1;
                out_data  = w_status;
                if (out_ready) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The state register already sits in IDLE during reset; gating with
    // rst_n keeps in_ready low while reset is held.
    assign in_ready  = w_in_ready & rst_n;
    assign w_in_xfer = w_in_ready & in_valid;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            if (w_in_xfer && (r_state == S_IDLE))  r_op <= in_data[OPCODE_W-1:0];
            if (w_in_xfer && (r_state == S_GET_A)) r_a  <= in_data;
            if (w_in_xfer && (r_state == S_GET_B)) r_b  <= in_data;
            if (r_state == S_EXEC)                 r_result <= alu_result;
        end
    end

`ifdef SEQ_STATUS_BYTE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dz <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_dz <= w_dz_nxt;
        end
    end
`endif

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_ena;
    logic [15:0] alu_result;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_op_sequencer #(.DATA_W(8), .OPCODE_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_ena    (alu_ena),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, mul, div, mod, and, or, xor.
    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return 16'(a) + 16'(b);
            3'd1: return 16'(a) - 16'(b);
            3'd2: return 16'(a) * 16'(b);
            3'd3: return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
            3'd4: return (b == 8'd0) ? 16'(a) : 16'(a % b);
            3'd5: return 16'(a & b);
            3'd6: return 16'(a | b);
            default: return 16'(a ^ b);
        endcase
    endfunction

    // Result is only meaningful while enabled; a junk value elsewhere exposes
    // a capture at the wrong cycle.
    always_comb begin
        alu_result = 16'hDEAD;
        if (alu_ena) alu_result = alu_ref(alu_opcode, alu_a, alu_b);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=hung expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin tick(); t++; end
        check("send_timeout", 16'(t < 50), 16'd1);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic recv_byte(input logic [7:0] e, input int stall, input string tag);
        int t;
        t = 0;
        out_ready = 1'b0;
        while (!out_valid && t < 50) begin tick(); t++; end
        check({tag, "_timeout"}, 16'(t < 50), 16'd1);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            check({tag, "_stall_valid"}, 16'(out_valid), 16'd1);
            check({tag, "_stall_data"}, 16'(out_data), 16'(e));
            check({tag, "_stall_in_ready"}, 16'(in_ready), 16'd0);
            tick();
        end
        in_valid = 1'b0;
        check(tag, 16'(out_data), 16'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] op_b, input logic [7:0] a, input logic [7:0] b,
                           input int gap, input int stall,
                           input logic [7:0] e_lo, input logic [7:0] e_hi, input logic [7:0] e_st);
        logic [2:0] e_op;
        e_op = op_b[2:0];
        send_byte(op_b, gap);
        send_byte(a, gap);
        send_byte(b, gap);
        check("exec_ena", 16'(alu_ena), 16'd1);
        check("exec_in_ready", 16'(in_ready), 16'd0);
        check("exec_busy", 16'(busy), 16'd1);
        check("exec_opcode", 16'(alu_opcode), 16'(e_op));
        check("exec_a", 16'(alu_a), 16'(a));
        check("exec_b", 16'(alu_b), 16'(b));
        tick();
        check("ena_one_cycle", 16'(alu_ena), 16'd0);
        check("out_valid_latency", 16'(out_valid), 16'd1);
        recv_byte(e_lo, stall, "byte_lo");
        check("hi_valid", 16'(out_valid), 16'd1);
        recv_byte(e_hi, 0, "byte_hi");
`ifdef SEQ_STATUS_BYTE_EN
        recv_byte(e_st, 0, "byte_st");
`endif
        check("done_busy", 16'(busy), 16'd0);
        check("done_in_ready", 16'(in_ready), 16'd1);
        check("done_out_valid", 16'(out_valid), 16'd0);
        check("hold_opcode", 16'(alu_opcode), 16'(e_op));
        check("hold_a", 16'(alu_a), 16'(a));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 16'(in_ready), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
        check({tag, "_ena"}, 16'(alu_ena), 16'd0);
        check({tag, "_out_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_out_data"}, 16'(out_data), 16'd0);
        check({tag, "_a"}, 16'(alu_a), 16'd0);
        check({tag, "_b"}, 16'(alu_b), 16'd0);
        check({tag, "_opcode"}, 16'(alu_opcode), 16'd0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [7:0]  r_a, r_b;
        logic [15:0] r_res;
        logic        r_dz;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", 16'(in_ready), 16'd1);

        // ADD, MUL, backpressure, gaps with upper opcode bits ignored
        run_cmd(8'h00, 8'd15, 8'd10, 0, 0, 8'h19, 8'h00, 8'h00);
        run_cmd(8'h02, 8'd200, 8'd200, 0, 0, 8'h40, 8'h9C, 8'h04);
        run_cmd(8'h02, 8'd200, 8'd200, 0, 3, 8'h40, 8'h9C, 8'h04);
        run_cmd(8'hF9, 8'd20, 8'd7, 2, 0, 8'h0D, 8'h00, 8'h02);

        // Reset while waiting for B
        send_byte(8'h02, 0);
        send_byte(8'd55, 0);
        check("get_b_busy", 16'(busy), 16'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_get_b");
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while presenting the high byte
        send_byte(8'h00, 0);
        send_byte(8'd3, 0);
        send_byte(8'd4, 0);
        tick();
        recv_byte(8'h07, 0, "pre_rst_lo");
        check("out_hi_valid", 16'(out_valid), 16'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_out_hi");
        tick();
        rst_n = 1'b1;
        tick();
        run_cmd(8'h00, 8'd1, 8'd1, 0, 0, 8'h02, 8'h00, 8'h00);

        // Divide by zero and a plain add afterwards
        run_cmd(8'h03, 8'd100, 8'd0, 0, 0, 8'hFF, 8'hFF, 8'h07);
        run_cmd(8'h00, 8'd1, 8'd1, 0, 0, 8'h02, 8'h00, 8'h00);

        // Randomised commands against the behavioural ALU
        for (int n = 0; n < 40; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_a   = 8'($urandom);
            r_b   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            r_res = alu_ref(r_op, r_a, r_b);
            r_dz  = ((r_op == 3'd3) || (r_op == 3'd4)) && (r_b == 8'd0);
            run_cmd({5'($urandom), r_op}, r_a, r_b,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    r_res[7:0], r_res[15:8], {4'b0000, r_op, r_dz});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
